muldiv_unit: RTL and testbench

//  EX-stage consumer of alucontrol for MULT/MULTU/DIV/DIVU. Owns the HI/LO

---
 rtl/muldiv_unit_pkg.sv | 49 ++++
 rtl/muldiv_unit_div_radix2.sv | 81 ++++++++
 rtl/muldiv_unit.sv | 193 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
//  - alucontrol codes for MULT/MULTU/DIV/DIVU as produced by the ALU decoder
//  - FSM state encodings (3-bit localparams)
//  - small decode helpers used by the unit and its environment
package muldiv_unit_pkg;

    localparam logic [4:0] MULT_CONTROL  = 5'b11000;
    localparam logic [4:0] MULTU_CONTROL = 5'b11001;
    localparam logic [4:0] DIV_CONTROL   = 5'b11010;
    localparam logic [4:0] DIVU_CONTROL  = 5'b11011;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] MUL  = 3'd1;
    localparam logic [2:0] DIV  = 3'd2;
    localparam logic [2:0] FIX  = 3'd3;
    localparam logic [2:0] ZERO = 3'd4;

    // True for any op this unit executes.
    function automatic logic is_muldiv_op(input logic [4:0] ctrl);
        logic r;
        case (ctrl)
            MULT_CONTROL, MULTU_CONTROL,
            DIV_CONTROL,  DIVU_CONTROL:  r = 1'b1;
            default:                     r = 1'b0;
        endcase
        return r;
    endfunction

    // True for DIV/DIVU.
    function automatic logic is_div_op(input logic [4:0] ctrl);
        logic r;
        case (ctrl)
            DIV_CONTROL, DIVU_CONTROL: r = 1'b1;
            default:                   r = 1'b0;
        endcase
        return r;
    endfunction

    // True for the signed variants MULT/DIV.
    function automatic logic is_signed_op(input logic [4:0] ctrl);
        logic r;
        case (ctrl)
            MULT_CONTROL, DIV_CONTROL: r = 1'b1;
            default:                   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/muldiv_unit_div_radix2.sv
// Iterative radix-2 restoring divider on unsigned magnitudes.
// One quotient bit per cycle, ITERS cycles after start.
//  clk, rst_n  clock / asynchronous active-low reset
//  start       load dividend/divisor and begin iterating
//  cancel      abandon the current division
//  dividend    unsigned dividend
//  divisor     unsigned divisor (caller guarantees non-zero)
//  quotient    quotient (final after the edge ending the valid cycle)
//  remainder   remainder (final after the edge ending the valid cycle)
//  valid       high during the final iteration; results complete at that edge
module div_radix2 #(
    parameter int WIDTH = 32,
    parameter int ITERS = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cancel,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             valid
);

    localparam int CNT_W = $clog2(ITERS) + 1;

    logic [CNT_W-1:0] count;
    logic             busy;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] sub;

    // Trial subtraction: the quotient register doubles as the dividend
    // shift register, feeding its MSB into the partial remainder.
    always_comb begin
        shifted = {remainder, quotient[WIDTH-1]};
        fits    = (shifted >= {1'b0, dsr});
        // When fits, shifted - dsr < dsr, so WIDTH bits are enough.
        sub     = shifted[WIDTH-1:0] - dsr;
        valid   = busy && (count == CNT_W'(ITERS - 1));
    end

    // Divider datapath and iteration counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient  <= {WIDTH{1'b0}};
            remainder <= {WIDTH{1'b0}};
            dsr       <= {WIDTH{1'b0}};
            count     <= {CNT_W{1'b0}};
            busy      <= 1'b0;
        end else if (cancel) begin
            count <= {CNT_W{1'b0}};
            busy  <= 1'b0;
        end else if (start) begin
            quotient  <= dividend;
            remainder <= {WIDTH{1'b0}};
            dsr       <= divisor;
            count     <= {CNT_W{1'b0}};
            busy      <= 1'b1;
        end else if (busy) begin
            if (fits) begin
                remainder <= sub;
                quotient  <= {quotient[WIDTH-2:0], 1'b1};
            end else begin
                remainder <= shifted[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b0};
            end
            count <= count + CNT_W'(1);
            if (valid) begin
                busy <= 1'b0;
            end else begin
                busy <= 1'b1;
            end
        end else begin
            busy <= 1'b0;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage multiply/divide unit owning the HI/LO registers.
// MULT/MULTU finish in one cycle; DIV/DIVU run a radix-2 divider for
// DIV_ITERS cycles followed by a sign-fixup cycle. The pipeline is stalled
// until the cycle in which HI/LO are committed.
//  clk, rst_n   clock / asynchronous active-low reset
//  alucontrol   decoded ALU op
//  start        EX instruction valid (sampled only in IDLE)
//  cancel       flush: abort any in-flight op, HI/LO untouched
//  a, b         rs / rt operands
//  hi_we/lo_we  MTHI / MTLO write enables, data on wdata
//  stall        hold IF..EX this cycle
//  done         HI/LO take a muldiv result at the end of this cycle
//  hi, lo       architectural HI / LO
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       alucontrol,
    input  logic             start,
    input  logic             cancel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [2:0]         state;
    logic [2:0]         next_state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic               signed_op;
    logic               neg_q;
    logic               neg_r;

    logic               accept;
    logic               div_start;
    logic               b_zero;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   div_q;
    logic [WIDTH-1:0]   div_r;
    logic               div_last;
    logic [WIDTH-1:0]   fix_q;
    logic [WIDTH-1:0]   fix_r;

    // Accept decode, operand magnitudes, product and sign fixup.
    always_comb begin
        b_zero    = (b == {WIDTH{1'b0}});
        accept    = (state == IDLE) && start && !cancel && is_muldiv_op(alucontrol);
        div_start = accept && is_div_op(alucontrol) && !b_zero;
        if (is_signed_op(alucontrol) && a[WIDTH-1]) begin
            a_mag = {WIDTH{1'b0}} - a;
        end else begin
            a_mag = a;
        end
        if (is_signed_op(alucontrol) && b[WIDTH-1]) begin
            b_mag = {WIDTH{1'b0}} - b;
        end else begin
            b_mag = b;
        end
        // Sign-extending to 2*WIDTH makes one unsigned multiply serve both.
        ext_a   = {{WIDTH{signed_op & a_reg[WIDTH-1]}}, a_reg};
        ext_b   = {{WIDTH{signed_op & b_reg[WIDTH-1]}}, b_reg};
        product = ext_a * ext_b;
        if (neg_q) begin
            fix_q = {WIDTH{1'b0}} - div_q;
        end else begin
            fix_q = div_q;
        end
        if (neg_r) begin
            fix_r = {WIDTH{1'b0}} - div_r;
        end else begin
            fix_r = div_r;
        end
    end

    // Next-state logic; cancel overrides every transition.
    always_comb begin
        next_state = IDLE;
        if (cancel) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!accept) begin
                        next_state = IDLE;
                    end else if (!is_div_op(alucontrol)) begin
                        next_state = MUL;
                    end else if (b_zero) begin
                        next_state = ZERO;
                    end else begin
                        next_state = DIV;
                    end
                end
                DIV: begin
                    if (div_last) begin
                        next_state = FIX;
                    end else begin
                        next_state = DIV;
                    end
                end
                MUL, FIX, ZERO: next_state = IDLE;
                default:        next_state = IDLE;
            endcase
        end
    end

    // Stall drops in commit cycles so the pipeline advances on the same edge
    // that writes HI/LO.
    always_comb begin
        stall = accept || ((state == DIV) && !cancel);
        done  = ((state == MUL) || (state == FIX) || (state == ZERO)) && !cancel;
    end

    // State and latched operand information.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= {WIDTH{1'b0}};
            b_reg     <= {WIDTH{1'b0}};
            signed_op <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                a_reg     <= a;
                b_reg     <= b;
                signed_op <= is_signed_op(alucontrol);
                neg_q     <= is_signed_op(alucontrol) & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r     <= is_signed_op(alucontrol) & a[WIDTH-1];
            end else begin
                signed_op <= signed_op;
            end
        end
    end

    // HI/LO: muldiv commits win; MTHI/MTLO only land in an idle, non-accepting cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= {WIDTH{1'b0}};
            lo <= {WIDTH{1'b0}};
        end else if ((state == MUL) && !cancel) begin
            hi <= product[2*WIDTH-1:WIDTH];
            lo <= product[WIDTH-1:0];
        end else if ((state == FIX) && !cancel) begin
            hi <= fix_r;
            lo <= fix_q;
        end else if ((state == IDLE) && !accept) begin
            if (hi_we) begin
                hi <= wdata;
            end else begin
                hi <= hi;
            end
            if (lo_we) begin
                lo <= wdata;
            end else begin
                lo <= lo;
            end
        end else begin
            hi <= hi;
            lo <= lo;
        end
    end

    div_radix2 #(
        .WIDTH (WIDTH),
        .ITERS (DIV_ITERS)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .cancel    (cancel),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (div_q),
        .remainder (div_r),
        .valid     (div_last)
    );

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases followed by
// random MULT/MULTU/DIV/DIVU ops checked against an arithmetic reference.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  alucontrol = 5'd0;
    logic        start = 1'b0;
    logic        cancel = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] wdata = 32'd0;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] ref_hi = 32'd0;
    logic [31:0] ref_lo = 32'd0;

    muldiv_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alucontrol (alucontrol),
        .start      (start),
        .cancel     (cancel),
        .a          (a),
        .b          (b),
        .hi_we      (hi_we),
        .lo_we      (lo_we),
        .wdata      (wdata),
        .stall      (stall),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural result of one op: HI/LO after commit and cycles to done.
    task automatic model(input logic [4:0] ctrl, input logic [31:0] x, input logic [31:0] y,
                         inout logic [31:0] h, inout logic [31:0] l, output int lat);
        longint      sq;
        longint      sr;
        logic [63:0] p;
        lat = 1;
        case (ctrl)
            MULT_CONTROL: begin
                p = 64'(longint'($signed(x)) * longint'($signed(y)));
                h = p[63:32];
                l = p[31:0];
            end
            MULTU_CONTROL: begin
                p = {32'd0, x} * {32'd0, y};
                h = p[63:32];
                l = p[31:0];
            end
            DIV_CONTROL: begin
                if (y != 32'd0) begin
                    sq = longint'($signed(x)) / longint'($signed(y));
                    sr = longint'($signed(x)) % longint'($signed(y));
                    p  = 64'(sq);
                    l  = p[31:0];
                    p  = 64'(sr);
                    h  = p[31:0];
                    lat = 33;
                end
            end
            DIVU_CONTROL: begin
                if (y != 32'd0) begin
                    l = x / y;
                    h = x % y;
                    lat = 33;
                end
            end
            default: lat = 0;
        endcase
    endtask

    // Issue one op in cycle 0 and follow it to its commit.
    task automatic run_op(input string tag, input logic [4:0] ctrl,
                          input logic [31:0] op_a, input logic [31:0] op_b);
        int exp_lat;
        int lat;
        logic got;
        model(ctrl, op_a, op_b, ref_hi, ref_lo, exp_lat);
        @(posedge clk); #1;
        alucontrol = ctrl; a = op_a; b = op_b; start = 1'b1;
        @(negedge clk);
        check({tag, "_stall_c0"}, 64'(stall), 64'd1);
        check({tag, "_done_c0"}, 64'(done), 64'd0);
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        lat = 1;
        got = 1'b0;
        while (!got && lat <= 40) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got = 1'b1;
                check({tag, "_stall_commit"}, 64'(stall), 64'd0);
            end else begin
                if (lat == 1 || lat == 32) check({tag, "_stall_busy"}, 64'(stall), 64'd1);
                @(posedge clk); #1;
                lat++;
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        @(posedge clk); #1;
        check({tag, "_hi"}, 64'(hi), 64'(ref_hi));
        check({tag, "_lo"}, 64'(lo), 64'(ref_lo));
    endtask

    task automatic write_hilo(input logic we_h, input logic we_l, input logic [31:0] d);
        @(posedge clk); #1;
        hi_we = we_h; lo_we = we_l; wdata = d;
        @(posedge clk); #1;
        hi_we = 1'b0; lo_we = 1'b0;
        if (we_h) ref_hi = d;
        if (we_l) ref_lo = d;
    endtask

    logic [4:0] ops [4];

    initial begin
        int dn;
        ops[0] = MULT_CONTROL;
        ops[1] = MULTU_CONTROL;
        ops[2] = DIV_CONTROL;
        ops[3] = DIVU_CONTROL;

        // Reset state
        #12;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed ops
        run_op("mult_neg", MULT_CONTROL, 32'hFFFFFFFF, 32'd2);
        run_op("multu_big", MULTU_CONTROL, 32'hFFFFFFFF, 32'd2);
        run_op("div_m7_2", DIV_CONTROL, 32'hFFFFFFF9, 32'd2);
        run_op("div_ovf", DIV_CONTROL, 32'h80000000, 32'hFFFFFFFF);
        write_hilo(1'b1, 1'b1, 32'h1234);
        check("mt_hi", 64'(hi), 64'h1234);
        check("mt_lo", 64'(lo), 64'h1234);
        run_op("divu_by0", DIVU_CONTROL, 32'd100, 32'd0);

        // Non-muldiv code is ignored
        @(posedge clk); #1;
        alucontrol = 5'b00010; a = 32'd5; b = 32'd6; start = 1'b1;
        @(negedge clk);
        check("other_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("other_done", 64'(done), 64'd0);
        check("other_lo", 64'(lo), 64'(ref_lo));

        // Cancel a DIV at cycle 10
        @(posedge clk); #1;
        alucontrol = DIV_CONTROL; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // MTHI while busy must be dropped
        hi_we = 1'b1; wdata = 32'hDEAD;
        @(posedge clk); #1;
        hi_we = 1'b0;
        for (int i = 2; i < 10; i++) begin
            @(posedge clk); #1;
        end
        cancel = 1'b1;
        @(negedge clk);
        check("cancel_stall", 64'(stall), 64'd0);
        check("cancel_done", 64'(done), 64'd0);
        @(posedge clk); #1;
        cancel = 1'b0;
        @(negedge clk);
        check("cancel_idle_stall", 64'(stall), 64'd0);
        check("cancel_hi", 64'(hi), 64'(ref_hi));
        check("cancel_lo", 64'(lo), 64'(ref_lo));
        write_hilo(1'b0, 1'b1, 32'h55);
        check("mtlo_after_cancel", 64'(lo), 64'h55);
        dn = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        check("cancel_no_done", 64'(dn), 64'd0);

        // Reset in the middle of a DIVU
        run_op("mult_pre_rst", MULT_CONTROL, 32'h00012345, 32'h00067890);
        @(posedge clk); #1;
        alucontrol = DIVU_CONTROL; a = 32'hFFFFFFFF; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        check("midrst_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        ref_hi = 32'd0;
        ref_lo = 32'd0;
        run_op("divu_fresh", DIVU_CONTROL, 32'hFFFFFFFF, 32'd3);

        // Random ops
        for (int k = 0; k < 24; k++) begin
            logic [4:0]  c;
            logic [31:0] x;
            logic [31:0] y;
            c = ops[$urandom_range(0, 3)];
            x = $urandom;
            case ($urandom_range(0, 5))
                0:       y = 32'd0;
                1:       y = 32'($urandom_range(1, 15));
                2:       y = 32'hFFFFFFFF;
                default: y = $urandom;
            endcase
            run_op("rand", c, x, y);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
